// File: rtl/io_pkg.sv
// Shared constants and types for the IO responder: page base, register offsets,
// and the switch debounce state encoding.
package io_pkg;

    localparam logic [31:0] IO_BASE_DEFAULT = 32'hFFFF_FC00;

    localparam logic [7:0] OFF_LED_LO = 8'h60;
    localparam logic [7:0] OFF_LED_HI = 8'h62;
    localparam logic [7:0] OFF_BLINK  = 8'h64;
    localparam logic [7:0] OFF_SW_LO  = 8'h70;
    localparam logic [7:0] OFF_SW_HI  = 8'h72;

    typedef enum logic {
        STABLE   = 1'b0,
        COUNTING = 1'b1
    } db_state_e;

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchroniser followed by a bank-wide debouncer: a new switch pattern
// is committed only after it has been seen unchanged for DEBOUNCE_CYCLES cycles.
module sw_debounce
    import io_pkg::*;
#(
    parameter int unsigned WIDTH           = 24,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] raw_i,
    output logic [WIDTH-1:0] deb_o
);

    localparam int unsigned      CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [WIDTH-1:0] deb_q,  deb_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;
    db_state_e        state_q, state_d;

    // State register, synchroniser chain and debounce datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
            cand_q  <= '0;
            deb_q   <= '0;
            cnt_q   <= '0;
            state_q <= STABLE;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            cand_q  <= cand_d;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    // Debounce FSM: any change of the synchronised bank restarts the stability count
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        deb_d   = deb_q;
        unique case (state_q)
            STABLE: begin
                if (sync2_q != deb_q) begin
                    cand_d  = sync2_q;
                    cnt_d   = '0;
                    state_d = COUNTING;
                end
            end
            COUNTING: begin
                if (sync2_q == deb_q) begin
                    cnt_d   = '0;
                    state_d = STABLE;
                end else if (sync2_q != cand_q) begin
                    cand_d = sync2_q;
                    cnt_d  = '0;
                end else if (cnt_q == CNT_MAX) begin
                    deb_d   = cand_q;
                    cnt_d   = '0;
                    state_d = STABLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    assign deb_o = deb_q;

endmodule

// File: rtl/io_responder.sv
// Memory-mapped IO responder: LED registers, debounced switch readback and a
// registered read-data return path. Build macro IO_BLINK_EN adds a blink mask
// register at offset 0x64 and a blink timebase on LED[15:0].
module io_responder
    import io_pkg::*;
#(
    parameter logic [31:0] IO_BASE         = IO_BASE_DEFAULT,
    parameter int unsigned SW_WIDTH        = 24,
    parameter int unsigned LED_WIDTH       = 24,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
`ifdef IO_BLINK_EN
    ,
    parameter int unsigned BLINK_DIV       = 50000000
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 led_ctrl,
    input  logic                 switch_ctrl,
    input  logic [31:0]          io_addr,
    input  logic [15:0]          io_wdata,
    output logic [15:0]          io_rdata,
    input  logic [SW_WIDTH-1:0]  sw_in,
    output logic [LED_WIDTH-1:0] led_out
);

    logic                 page_hit_c;
    logic [7:0]           off_c;
    logic [15:0]          rd_mux_c;
    logic [LED_WIDTH-1:0] led_q, led_d;
    logic [15:0]          rdata_q, rdata_d;
    logic [SW_WIDTH-1:0]  sw_deb;

    assign page_hit_c = (io_addr[31:8] == IO_BASE[31:8]);
    assign off_c      = io_addr[7:0];

    sw_debounce #(
        .WIDTH           (SW_WIDTH),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_sw_debounce (
        .clk_i (clk),
        .rst_i (rst),
        .raw_i (sw_in),
        .deb_o (sw_deb)
    );

`ifdef IO_BLINK_EN
    localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [15:0]        mask_q, mask_d;
    logic [BLINK_W-1:0] bcnt_q, bcnt_d;
    logic               phase_q, phase_d;

    // Blink mask write and free-running phase timebase
    always_comb begin
        mask_d  = mask_q;
        bcnt_d  = bcnt_q + BLINK_W'(1);
        phase_d = phase_q;
        if (led_ctrl && page_hit_c && (off_c == OFF_BLINK)) begin
            mask_d = io_wdata;
        end
        if (bcnt_q == BLINK_W'(BLINK_DIV - 1)) begin
            bcnt_d  = '0;
            phase_d = ~phase_q;
        end
    end

    // Blink registers
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q  <= '0;
            bcnt_q  <= '0;
            phase_q <= 1'b0;
        end else begin
            mask_q  <= mask_d;
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
        end
    end

    // Masked LEDs are dark during the low blink phase
    assign led_out = led_q & ~LED_WIDTH'(mask_q & ~{16{phase_q}});
`else
    assign led_out = led_q;
`endif

    // LED register writes; other offsets and page misses are ignored
    always_comb begin
        led_d = led_q;
        if (led_ctrl && page_hit_c) begin
            if (off_c == OFF_LED_LO) begin
                led_d[15:0] = io_wdata;
            end else if (off_c == OFF_LED_HI) begin
                led_d[LED_WIDTH-1:16] = io_wdata[LED_WIDTH-17:0];
            end
        end
    end

    // Read mux over the IO page; unmapped offsets read as zero
    always_comb begin
        rd_mux_c = '0;
        if (page_hit_c) begin
            case (off_c)
                OFF_LED_LO: rd_mux_c = led_q[15:0];
                OFF_LED_HI: rd_mux_c = 16'(led_q[LED_WIDTH-1:16]);
`ifdef IO_BLINK_EN
                OFF_BLINK:  rd_mux_c = mask_q;
`endif
                OFF_SW_LO:  rd_mux_c = sw_deb[15:0];
                OFF_SW_HI:  rd_mux_c = 16'(sw_deb[SW_WIDTH-1:16]);
                default:    rd_mux_c = '0;
            endcase
        end
    end

    // Read data loads on a read strobe; a concurrent write forces zero
    always_comb begin
        rdata_d = rdata_q;
        if (switch_ctrl) begin
            rdata_d = led_ctrl ? 16'h0000 : rd_mux_c;
        end
    end

    // LED and read-data registers
    always_ff @(posedge clk) begin
        if (rst) begin
            led_q   <= '0;
            rdata_q <= '0;
        end else begin
            led_q   <= led_d;
            rdata_q <= rdata_d;
        end
    end

    assign io_rdata = rdata_q;

endmodule

// File: tb/tb_io_responder.sv
// Scoreboard bench for io_responder (DEBOUNCE_CYCLES=4, BLINK_DIV=8).
// Stimulus pushes expected read data / LED values; a monitor pops and compares.
module tb_io_responder;

    localparam int unsigned DC = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        led_ctrl = 1'b0;
    logic        switch_ctrl = 1'b0;
    logic [31:0] io_addr = 32'h0;
    logic [15:0] io_wdata = 16'h0;
    logic [15:0] io_rdata;
    logic [23:0] sw_in = 24'h0;
    logic [23:0] led_out;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_rd[$];
    logic [23:0] exp_led[$];

    // Reference model state
    logic [23:0] m_led = 24'h0;
    logic [23:0] m_sw = 24'h0;
    logic [23:0] cur_raw = 24'h0;
    logic [15:0] m_mask = 16'h0;
    logic        blink_test = 1'b0;

    // Monitor state
    logic        rd_seen = 1'b0;
    logic        wr_seen = 1'b0;
    logic        rst_seen = 1'b0;
    logic [15:0] last_rd = 16'h0;
    logic [23:0] last_led = 24'h0;

    logic [7:0] offs [7] = '{8'h60, 8'h62, 8'h64, 8'h70, 8'h72, 8'h80, 8'h61};

    always #5 clk = ~clk;

    io_responder #(
        .DEBOUNCE_CYCLES (DC)
`ifdef IO_BLINK_EN
        , .BLINK_DIV     (8)
`endif
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .led_ctrl    (led_ctrl),
        .switch_ctrl (switch_ctrl),
        .io_addr     (io_addr),
        .io_wdata    (io_wdata),
        .io_rdata    (io_rdata),
        .sw_in       (sw_in),
        .led_out     (led_out)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_read(input logic [31:0] a);
        if (a[31:8] != 24'hFFFFFC) return 16'h0000;
        case (a[7:0])
            8'h60: return m_led[15:0];
            8'h62: return {8'h00, m_led[23:16]};
`ifdef IO_BLINK_EN
            8'h64: return m_mask;
`endif
            8'h70: return m_sw[15:0];
            8'h72: return {8'h00, m_sw[23:16]};
            default: return 16'h0000;
        endcase
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [15:0] d);
        if (a[31:8] == 24'hFFFFFC) begin
            if (a[7:0] == 8'h60) m_led[15:0] = d;
            else if (a[7:0] == 8'h62) m_led[23:16] = d[7:0];
`ifdef IO_BLINK_EN
            else if (a[7:0] == 8'h64) m_mask = d;
`endif
        end
    endtask

    // One bus cycle; expectations are queued before the DUT sees the strobe
    task automatic bus(input logic w, input logic r, input logic [31:0] a, input logic [15:0] d);
        @(negedge clk);
        led_ctrl    = w;
        switch_ctrl = r;
        io_addr     = a;
        io_wdata    = d;
        if (r) exp_rd.push_back(w ? 16'h0000 : model_read(a));
        if (w) begin
            model_write(a, d);
            exp_led.push_back(m_led);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            led_ctrl    = 1'b0;
            switch_ctrl = 1'b0;
        end
    endtask

    // Hold a switch pattern; long enough holds become the debounced value
    task automatic hold_sw(input logic [23:0] v, input int n);
        @(negedge clk);
        led_ctrl    = 1'b0;
        switch_ctrl = 1'b0;
        sw_in       = v;
        cur_raw     = v;
        idle(n - 1);
        if (n >= int'(DC) + 3) m_sw = v;
    endtask

    // Short excursion that must never be committed
    task automatic glitch(input logic [23:0] v, input int n);
        @(negedge clk);
        led_ctrl    = 1'b0;
        switch_ctrl = 1'b0;
        sw_in       = v;
        idle(n - 1);
        @(negedge clk);
        sw_in = cur_raw;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst         = 1'b1;
        led_ctrl    = 1'b0;
        switch_ctrl = 1'b0;
        @(negedge clk);
        rst    = 1'b0;
        m_led  = 24'h0;
        m_sw   = 24'h0;
        m_mask = 16'h0;
    endtask

    // Monitor: note what the DUT saw on each active edge
    always @(posedge clk) begin
        rst_seen <= rst;
        rd_seen  <= switch_ctrl & ~rst;
        wr_seen  <= led_ctrl & ~rst;
    end

    // Monitor: compare outputs half a cycle after the edge
    always @(negedge clk) begin
        logic [15:0] er;
        logic [23:0] el;
        if (rst_seen) begin
            chk("reset_led_out", 32'(led_out), 32'h0);
            chk("reset_io_rdata", 32'(io_rdata), 32'h0);
            last_rd  = 16'h0;
            last_led = 24'h0;
        end else begin
            if (rd_seen) begin
                if (exp_rd.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_underflow: got %0h expected none", io_rdata);
                end else begin
                    er = exp_rd.pop_front();
                    chk("io_rdata", 32'(io_rdata), 32'(er));
                    last_rd = er;
                end
            end else begin
                chk("io_rdata_hold", 32'(io_rdata), 32'(last_rd));
            end
            if (wr_seen) begin
                if (exp_led.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL led_underflow: got %0h expected none", led_out);
                end else begin
                    el = exp_led.pop_front();
                    if (!blink_test) chk("led_out", 32'(led_out), 32'(el));
                    last_led = el;
                end
            end else if (!blink_test) begin
                chk("led_out_hold", 32'(led_out), 32'(last_led));
            end
        end
    end

    initial begin
        logic [7:0]  off;
        logic [31:0] a;
        logic        w;
        logic        r;
        int          op;

        repeat (2) @(negedge clk);
        rst = 1'b0;

        // LED writes
        bus(1'b1, 1'b0, 32'hFFFFFC60, 16'hA5A5);
        bus(1'b1, 1'b0, 32'hFFFFFC62, 16'h00FF);
        bus(1'b0, 1'b1, 32'hFFFFFC62, 16'h0);
        idle(1);
        chk("led_two_writes", 32'(led_out), 32'hFFA5A5);

        // Bounce rejection
        glitch(24'h000003, 3);
        idle(2);
        bus(1'b0, 1'b1, 32'hFFFFFC70, 16'h0);

        // Debounce commit
        hold_sw(24'h123456, 8);
        bus(1'b0, 1'b1, 32'hFFFFFC70, 16'h0);
        bus(1'b0, 1'b1, 32'hFFFFFC72, 16'h0);

        // Unmapped write, page miss read, collision
        bus(1'b1, 1'b0, 32'hFFFFFC80, 16'hDEAD);
        bus(1'b0, 1'b1, 32'hFFFFFD60, 16'h0);
        bus(1'b1, 1'b1, 32'hFFFFFC60, 16'h1234);
        bus(1'b1, 1'b0, 32'hFFFFFC60, 16'hA5A5);
        idle(1);
        chk("led_before_reset", 32'(led_out), 32'hFFA5A5);

        // Reset while the debouncer is counting
        hold_sw(24'h654321, 4);
        do_reset();
        bus(1'b0, 1'b1, 32'hFFFFFC70, 16'h0);
        hold_sw(24'h654321, 8);
        bus(1'b0, 1'b1, 32'hFFFFFC70, 16'h0);
        bus(1'b0, 1'b1, 32'hFFFFFC72, 16'h0);

        // Randomised traffic against the reference model
        for (int ep = 0; ep < 30; ep++) begin
            if ($urandom_range(0, 2) == 0) glitch(24'($urandom), int'($urandom_range(1, DC)));
            else hold_sw(24'($urandom), int'($urandom_range(DC + 3, DC + 10)));
            repeat (6) begin
                op  = int'($urandom_range(0, 9));
                w   = (op < 4) || (op == 9);
                r   = (op >= 4);
                off = offs[$urandom_range(0, 6)];
`ifdef IO_BLINK_EN
                if (w && off == 8'h64) off = 8'h60;
`endif
                a = {($urandom_range(0, 7) == 0) ? 24'hFFFFFD : 24'hFFFFFC, off};
                bus(w, r, a, 16'($urandom));
                if ($urandom_range(0, 3) == 0) idle(1);
            end
        end

`ifdef IO_BLINK_EN
        // Blink: masked nibble toggles every 8 cycles, unmasked bits stay lit
        begin
            logic [3:0] prev;
            int         run;
            int         nruns;
            logic       first;
            blink_test = 1'b1;
            bus(1'b1, 1'b0, 32'hFFFFFC64, 16'h000F);
            bus(1'b1, 1'b0, 32'hFFFFFC60, 16'h00FF);
            bus(1'b1, 1'b0, 32'hFFFFFC62, 16'h0000);
            bus(1'b0, 1'b1, 32'hFFFFFC64, 16'h0);
            idle(1);
            prev  = led_out[3:0];
            run   = 0;
            nruns = 0;
            first = 1'b1;
            repeat (40) begin
                idle(1);
                chk("blink_upper", 32'(led_out[23:4]), 32'h0000F);
                chk("blink_nibble_level", 32'((led_out[3:0] == 4'h0) || (led_out[3:0] == 4'hF)), 32'h1);
                if (led_out[3:0] != prev) begin
                    if (!first) begin
                        chk("blink_run_len", 32'(run), 32'd8);
                        nruns++;
                    end
                    first = 1'b0;
                    run   = 1;
                    prev  = led_out[3:0];
                end else begin
                    run++;
                end
            end
            chk("blink_runs_seen", 32'(nruns >= 2), 32'h1);
        end
`endif

        idle(3);
        chk("rd_queue_drained", 32'(exp_rd.size()), 32'h0);
        chk("led_queue_drained", 32'(exp_led.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
